// File: rtl/flight_call_pkg.sv
// flight_call_pkg: shared FSM encoding and defaults for the cabin call arbiter
package flight_call_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;
  localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/rr_seat_picker.sv
// rr_seat_picker: wrap-around priority search starting just after last_grant
module rr_seat_picker #(
  parameter int NUM_SEATS = 4,
  parameter int SEAT_W    = 2
) (
  input  logic [NUM_SEATS-1:0] req,
  input  logic [SEAT_W-1:0]    last_grant,
  output logic                 found,
  output logic [SEAT_W-1:0]    seat
);
  // Walk from farthest to nearest so the nearest lit seat wins last.
  always_comb begin
    found = 1'b0;
    seat  = '0;
    for (int k = NUM_SEATS; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_SEATS]) begin
        found = 1'b1;
        seat  = SEAT_W'((int'(last_grant) + k) % NUM_SEATS);
      end
    end
  end
endmodule

// File: rtl/flight_attendant_call_arbiter.sv
// flight_attendant_call_arbiter: latches seat call lights and round-robins one attendant
module flight_attendant_call_arbiter
  import flight_call_pkg::*;
#(
  parameter int NUM_SEATS      = 4,
  parameter int SEAT_W         = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SEATS-1:0] call_button,
  input  logic [NUM_SEATS-1:0] cancel_button,
  output logic [NUM_SEATS-1:0] light_state,
  output logic                 dispatch_valid,
  output logic [SEAT_W-1:0]    dispatch_seat,
  input  logic                 dispatch_ready,
  input  logic                 service_done,
  output logic                 busy,
  output logic                 escalate
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ESC = CW'(TIMEOUT_CYCLES - 2);
  state_t                state;
  logic [SEAT_W-1:0]     last_grant;
  logic [SEAT_W-1:0]     pick;
  logic                  found;
  logic [CW-1:0]         wait_cnt;
  logic [NUM_SEATS-1:0]  done_clr;
  logic [NUM_SEATS-1:0]  light_next;
  assign done_clr   = (service_done && state == SERVICE) ? NUM_SEATS'(1) << dispatch_seat : '0;
  assign light_next = call_button | (light_state & ~cancel_button & ~done_clr);
  rr_seat_picker #(.NUM_SEATS(NUM_SEATS), .SEAT_W(SEAT_W)) u_picker (
    .req        (light_state),
    .last_grant (last_grant),
    .found      (found),
    .seat       (pick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light_state    <= '0;
      dispatch_valid <= 1'b0;
      dispatch_seat  <= '0;
      busy           <= 1'b0;
      escalate       <= 1'b0;
      state          <= IDLE;
      wait_cnt       <= '0;
      last_grant     <= SEAT_W'(NUM_SEATS - 1);
    end else begin
      light_state <= light_next;
      case (state)
        IDLE: if (found) begin
          dispatch_seat  <= pick;
          dispatch_valid <= 1'b1;
          state          <= OFFER;
        end
        OFFER: if (dispatch_ready) begin
          state          <= SERVICE;
          dispatch_valid <= 1'b0;
          busy           <= 1'b1;
          last_grant     <= dispatch_seat;
          wait_cnt       <= '0;
          escalate       <= 1'b0;
        end else if (!light_state[dispatch_seat]) begin
          state          <= IDLE;
          dispatch_valid <= 1'b0;
          wait_cnt       <= '0;
          escalate       <= 1'b0;
        end else begin
          wait_cnt <= (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
          escalate <= escalate | (wait_cnt >= CNT_ESC);
        end
        SERVICE: if (service_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flight_attendant_call_arbiter.sv
// tb_flight_attendant_call_arbiter: directed plus random checks against a behavioural model
module tb_flight_attendant_call_arbiter;
  localparam int N = 4;
  localparam int T = 16;
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] call_button, cancel_button, light_state;
  logic         dispatch_valid, dispatch_ready, service_done, busy, escalate;
  logic [1:0]   dispatch_seat;
  int checks = 0;
  int errors = 0;
  bit m_light[N];
  int m_mode, m_seat, m_last, m_wait;
  bit m_esc;

  flight_attendant_call_arbiter #(.NUM_SEATS(N), .SEAT_W(2), .TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .call_button    (call_button),
    .cancel_button  (cancel_button),
    .light_state    (light_state),
    .dispatch_valid (dispatch_valid),
    .dispatch_seat  (dispatch_seat),
    .dispatch_ready (dispatch_ready),
    .service_done   (service_done),
    .busy           (busy),
    .escalate       (escalate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_pack();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_light[i];
    return v;
  endfunction

  task automatic m_reset();
    foreach (m_light[i]) m_light[i] = 1'b0;
    m_mode = 0; m_seat = 0; m_last = N - 1; m_wait = 0; m_esc = 1'b0;
  endtask

  // Model: mode 0 waiting for calls, 1 offering, 2 attendant in service.
  task automatic m_update(input logic [N-1:0] c, input logic [N-1:0] x, input logic r, input logic d);
    bit nl[N];
    for (int i = 0; i < N; i++)
      nl[i] = c[i] || (m_light[i] && !x[i] && !(d && m_mode == 2 && m_seat == i));
    if (m_mode == 0) begin
      for (int k = 1; k <= N; k++)
        if (m_mode == 0 && m_light[(m_last + k) % N]) begin
          m_seat = (m_last + k) % N; m_mode = 1; m_wait = 0;
        end
    end else if (m_mode == 1) begin
      if (r) begin
        m_mode = 2; m_last = m_seat; m_wait = 0; m_esc = 1'b0;
      end else if (!m_light[m_seat]) begin
        m_mode = 0; m_wait = 0; m_esc = 1'b0;
      end else begin
        m_wait++;
        m_esc = (m_wait >= T - 1);
      end
    end else if (d) m_mode = 0;
    m_light = nl;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".light"}, 32'(light_state), 32'(m_pack()));
    chk({tag, ".valid"}, 32'(dispatch_valid), 32'(m_mode == 1));
    if (m_mode != 0) chk({tag, ".seat"}, 32'(dispatch_seat), 32'(m_seat));
    chk({tag, ".busy"}, 32'(busy), 32'(m_mode == 2));
    chk({tag, ".esc"}, 32'(escalate), 32'(m_esc));
  endtask

  task automatic step(input logic [N-1:0] c, input logic [N-1:0] x, input logic r, input logic d, input string tag);
    call_button = c; cancel_button = x; dispatch_ready = r; service_done = d;
    @(posedge clk);
    m_update(c, x, r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst.light", 32'(light_state), 0);
    chk("rst.valid", 32'(dispatch_valid), 0);
    chk("rst.seat", 32'(dispatch_seat), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.esc", 32'(escalate), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; call_button = '0; cancel_button = '0; dispatch_ready = 1'b0; service_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // Reset while servicing with lights 1011
    step(4'b1011, 4'b0000, 0, 0, "t1a");
    step(4'b0000, 4'b0000, 0, 0, "t1b");
    step(4'b0000, 4'b0000, 1, 0, "t1c");
    chk("t1.busy_before_rst", 32'(busy), 1);
    chk("t1.lights_before_rst", 32'(light_state), 32'hb);
    #2;
    do_reset();
    step(4'b0100, 4'b0000, 0, 0, "t1d");
    chk("t1.light_after_call", 32'(light_state), 32'h4);
    step(4'b0000, 4'b0000, 0, 0, "t1e");
    chk("t1.valid2", 32'(dispatch_valid), 1);
    chk("t1.seat2", 32'(dispatch_seat), 2);
    // Call beats cancel; then cancel withdraws an unaccepted offer
    step(4'b0010, 4'b0010, 0, 0, "t2a");
    chk("t2.call_wins", 32'(light_state[1]), 1);
    step(4'b0000, 4'b0000, 1, 0, "t2b");
    step(4'b0000, 4'b0000, 0, 1, "t2c");
    step(4'b0000, 4'b0000, 0, 0, "t2d");
    chk("t2.offer_seat1", 32'(dispatch_seat), 1);
    step(4'b0000, 4'b0010, 0, 0, "t2e");
    chk("t2.cancel_light", 32'(light_state[1]), 0);
    step(4'b0000, 4'b0000, 0, 0, "t2f");
    chk("t2.withdrawn", 32'(dispatch_valid), 0);
    chk("t2.no_esc", 32'(escalate), 0);
    // Round-robin over four lit seats, re-calling each seat as it finishes
    rst = 1'b1; #1; rst = 1'b0; m_reset();
    step(4'b1111, 4'b0000, 0, 0, "t3a");
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, 0, 0, "t3offer");
      chk("t3.rr_seat", 32'(dispatch_seat), 32'(i % N));
      step(4'b0000, 4'b0000, 1, 0, "t3acc");
      step(4'(1 << (i % N)), 4'b0000, 0, 1, "t3done");
    end
    // Timeout escalation on an ignored offer
    rst = 1'b1; #1; rst = 1'b0; m_reset();
    step(4'b1000, 4'b0000, 0, 0, "t4a");
    step(4'b0000, 4'b0000, 0, 0, "t4b");
    for (int i = 0; i < T - 2; i++) step(4'b0000, 4'b0000, 0, 0, "t4wait");
    chk("t4.not_yet", 32'(escalate), 0);
    step(4'b0000, 4'b0000, 0, 0, "t4c");
    chk("t4.escalate", 32'(escalate), 1);
    chk("t4.seat3", 32'(dispatch_seat), 3);
    step(4'b0000, 4'b0000, 0, 0, "t4sticky");
    step(4'b0000, 4'b0000, 1, 0, "t4d");
    chk("t4.busy", 32'(busy), 1);
    chk("t4.esc_clr", 32'(escalate), 0);
    // Re-call coincident with service_done; seat 0 goes to the back of the line
    rst = 1'b1; #1; rst = 1'b0; m_reset();
    step(4'b0001, 4'b0000, 0, 0, "t5a");
    step(4'b0000, 4'b0000, 0, 0, "t5b");
    step(4'b0000, 4'b0000, 1, 0, "t5c");
    step(4'b0110, 4'b0000, 1, 0, "t5d");
    step(4'b0001, 4'b0000, 0, 1, "t5e");
    chk("t5.relit0", 32'(light_state[0]), 1);
    for (int i = 1; i <= 3; i++) begin
      step(4'b0000, 4'b0000, 0, 0, "t5offer");
      chk("t5.rr_seat", 32'(dispatch_seat), 32'(i % 3));
      step(4'b0000, 4'b0000, 1, 0, "t5acc");
      step(4'b0000, 4'b0000, 0, 1, "t5done");
    end
    step(4'b0000, 4'b0000, 0, 1, "t5idle_done");
    chk("t5.idle_busy", 32'(busy), 0);
    chk("t5.idle_valid", 32'(dispatch_valid), 0);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0), "rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flight_attendant_call_arbiter.md
Name: flight_attendant_call_arbiter

Overview:
Multi-seat controller for the cabin call system. It latches each seat's call light and shares a single attendant between seats using a round-robin scheme. Requests are offered to the attendant interface with a valid/ready handshake, and the seat stays in service until the attendant reports completion. The block sits between the per-seat call/cancel buttons and the attendant station panel.

Parameters:
NUM_SEATS, 4, number of requesting seats (≥2)
SEAT_W, 2, width of the seat index; must equal clog2(NUM_SEATS)
TIMEOUT_CYCLES, 16, OFFER cycles without acceptance before escalate asserts (≥2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
call_button  in  NUM_SEATS  per-seat call request, sampled each edge
cancel_button  in  NUM_SEATS  per-seat cancel request, sampled each edge
light_state  out  NUM_SEATS  registered per-seat call light
dispatch_valid  out  1  an offer to the attendant is pending
dispatch_seat  out  SEAT_W  seat index being offered or serviced; held stable while dispatch_valid=1
dispatch_ready  in  1  attendant accepts the offer
service_done  in  1  attendant finished the current seat (single-cycle pulse)
busy  out  1  attendant is servicing a seat (state SERVICE)
escalate  out  1  offer has gone unaccepted for TIMEOUT_CYCLES

Behaviour:
- One clock (clk). rst is asynchronous and active-high. While rst=1: light_state=0, dispatch_valid=0, dispatch_seat=0, busy=0, escalate=0, state=IDLE, wait counter=0, last_grant=NUM_SEATS-1 (so seat 0 wins first). Reset mid-operation abandons any offer or service immediately.
- Light per seat i: light_next = call[i] | (light[i] & ~cancel[i] & ~done_clr[i]).
  - Call wins over cancel and over the service_done clear in the same cycle.
  - done_clr[i] = service_done & state==SERVICE & dispatch_seat==i.
  - Call with the light already on has no effect.
- All outputs are registered.
- FSM IDLE:
  - If any light bit is 1, select the first lit seat searching from (last_grant+1) upward, wrapping mod NUM_SEATS.
  - Register it into dispatch_seat and go to OFFER (dispatch_valid=1 the following cycle).
  - Otherwise stay in IDLE.
- FSM OFFER:
  - dispatch_valid=1.
  - If dispatch_ready=1: go to SERVICE, set last_grant=dispatch_seat, clear the counter and escalate. Acceptance takes priority over withdrawal in the same cycle.
  - Else if light[dispatch_seat]=0 (cancelled): withdraw. Go to IDLE, dispatch_valid=0, clear the counter and escalate. last_grant is unchanged.
  - Else increment the wait counter. When the counter reaches TIMEOUT_CYCLES-1, escalate=1 and stays 1 (sticky) until accept or withdraw. The counter saturates.
- FSM SERVICE:
  - busy=1, dispatch_valid=0, dispatch_seat held.
  - Cancel of the serviced seat clears its light but does not end service.
  - service_done=1: go to IDLE, busy=0.
  - dispatch_ready is ignored.
- Latency: a call sampled at edge k gives light=1 after edge k and dispatch_valid=1 after edge k+1 (if IDLE). After service_done, the next offer appears 2 edges later (SERVICE→IDLE→OFFER).
- service_done outside SERVICE is ignored.
- Seats requesting during SERVICE or OFFER are queued by their lights and arbitrated at the next IDLE.

Decomposition:
- Package flight_call_pkg: state encoding (IDLE=2'd0, OFFER=2'd1, SERVICE=2'd2) and the default TIMEOUT constant.
- Sub-module rr_seat_picker: combinational. Inputs are the request vector and last_grant; outputs are a found flag and the selected index (wrap-around priority search).
- The top level holds the light registers, the FSM, and the wait counter.

Test Plan:
1. Reset check: assert rst mid-SERVICE with lights=4'b1011 → all outputs 0 asynchronously. Release rst, call[2] pulse → light=4'b0100, dispatch_valid=1 with seat 2 two edges after the call.
2. Priority: call[1] and cancel[1] in the same cycle → light[1]=1. Then cancel[1] alone while in OFFER with ready=0 → light[1]=0, dispatch_valid drops the next cycle, no escalate.
3. Round-robin: lights 4'b1111, each offer accepted then done → dispatch_seat sequence 0,1,2,3,0.
4. Timeout: call[3], hold dispatch_ready=0 → escalate=1 after 16 OFFER cycles, seat 3 stable. Then ready=1 → busy=1, escalate=0.
5. Service interplay: during SERVICE of seat 0, call[0] coincident with service_done → light[0] stays 1, seat 0 is re-offered only after the other lit seats per round-robin. service_done pulsed in IDLE → no state change.
